// File: rtl/edp_pkg.sv
// rtl/edp_pkg.sv - shared select encodings, AD function codes and parity helper for the EDP slice
//
// Contents:
//   ada_sel_e / adb_sel_e  : adder operand source selects
//   arr_sel_e / arxr_sel_e : AR / ARX load source selects
//   mq_sel_e               : MQ hold / shift / load select
//   diag_sel_e             : EBUS diagnostic source select
//   AD_*                   : arithmetic-mode AD function codes
//   odd_parity()           : odd-parity bit of a (zero-extended) word
package edp_pkg;

    typedef enum logic [1:0] {ADA_AR, ADA_ARX, ADA_MQ, ADA_PC} ada_sel_e;
    typedef enum logic [1:0] {ADB_FM, ADB_BRX, ADB_BR, ADB_AR} adb_sel_e;
    typedef enum logic [1:0] {ARR_ARMM, ARR_CACHE, ARR_AD, ARR_SH} arr_sel_e;
    typedef enum logic [1:0] {ARXR_CACHE, ARXR_AD, ARXR_MQ, ARXR_SH} arxr_sel_e;
    typedef enum logic [1:0] {MQ_HOLD, MQ_SHR, MQ_SHL, MQ_AD} mq_sel_e;
    typedef enum logic [2:0] {
        DIAG_AR, DIAG_BR, DIAG_MQ, DIAG_FM, DIAG_ARX, DIAG_BRX, DIAG_PC, DIAG_ZERO
    } diag_sel_e;

    // Arithmetic-mode function codes; every other code behaves as A+B.
    localparam logic [3:0] AD_A          = 4'd0;
    localparam logic [3:0] AD_A_PLUS_B   = 4'd1;
    localparam logic [3:0] AD_A_PLUS_NB  = 4'd2;
    localparam logic [3:0] AD_A_PLUS_A   = 4'd3;
    localparam logic [3:0] AD_A_MINUS_1  = 4'd4;

    // Widest slice supported; narrower words are zero-extended, which leaves parity unchanged.
    localparam int MAX_WIDTH = 36;

    // Parity bit that makes the total number of ones (data + bit) odd.
    function automatic logic odd_parity(input logic [MAX_WIDTH-1:0] d);
        return ~(^d);
    endfunction

endpackage

// File: rtl/edp_fm.sv
// rtl/edp_fm.sv - fast-memory array with per-word odd parity, written bits and sticky parity error
//
// Ports:
//   clk, rst_l      : clock, asynchronous active-low reset (clears written bits and error only)
//   adr             : word address, read asynchronously, written at the edge
//   we, wdata       : write enable and write data
//   parity_clr      : clears parity_err, wins over a new error
//   rdata           : asynchronous read data
//   parity          : odd parity of rdata
//   parity_err      : sticky parity-error flag
module edp_fm
    import edp_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic [AW-1:0]    adr,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             parity_clr,
    output logic [WIDTH-1:0] rdata,
    output logic             parity,
    output logic             parity_err
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] par_mem;
    logic [DEPTH-1:0] written;
    logic             stored_par;
    logic             calc_par;

    // Data and stored parity are deliberately not reset; the written bits gate checking instead.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[adr]     <= wdata;
            par_mem[adr] <= odd_parity(MAX_WIDTH'(wdata));
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            written <= '0;
        end else if (we) begin
            written[adr] <= 1'b1;
        end
    end

    // Read sees the pre-edge contents, so a same-cycle write is visible only next cycle.
    assign rdata      = mem[adr];
    assign stored_par = par_mem[adr];
    assign calc_par   = odd_parity(MAX_WIDTH'(rdata));
    assign parity     = calc_par;

    // A word being rewritten is not checked: its stored parity is about to be replaced.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            parity_err <= 1'b0;
        end else if (parity_clr) begin
            parity_err <= 1'b0;
        end else if (written[adr] && !we && (calc_par != stored_par)) begin
            parity_err <= 1'b1;
        end
    end

endmodule

// File: rtl/edp_slice_n.sv
// rtl/edp_slice_n.sv - WIDTH-bit execution data path slice: AR/ARX/BR/BRX/MQ, AD unit, FM, EBUS readout
//
// Ports:
//   clk_edp_h, rst_l                 : clock, asynchronous active-low reset
//   cram_ad_*, cram_ada_*, cram_adb_sel, ad_cry_in : AD function, mode and operand controls
//   ad, ad_cry_out, ad_cg, ad_cp, ad_eq0_l         : combinational AD result and carry terms
//   ctl_arr_*, ctl_arxr_sel, ctl_arx_load, cram_br_load, cram_brx_load, ctl_mq_sel,
//   mq_in_left, mq_in_right          : register load / shift controls
//   armm, cache_data, sh, vma_held_or_pc : data sources
//   ar, arx, br, brx, mq             : register contents
//   fm_block, fm_adr, con_fm_write_l, fm_parity, fm_parity_err, fm_parity_clr : fast memory
//   ctl_ad_to_ebus, diag_read, diag_sel, ebus_d : registered EBUS readout
module edp_slice_n
    import edp_pkg::*;
#(
    parameter int WIDTH     = 6,
    parameter int FM_BLOCKS = 8,
    parameter int FM_ACS    = 16,
    parameter int FM_AW     = $clog2(FM_BLOCKS * FM_ACS)
) (
    input  logic                         clk_edp_h,
    input  logic                         rst_l,
    input  logic [3:0]                   cram_ad_sel,
    input  logic                         cram_ad_boole,
    input  logic [1:0]                   cram_ada_sel,
    input  logic                         cram_ada_dis,
    input  logic [1:0]                   cram_adb_sel,
    input  logic                         ad_cry_in,
    output logic                         ad_cry_out,
    output logic                         ad_cg,
    output logic                         ad_cp,
    output logic [WIDTH-1:0]             ad,
    output logic                         ad_eq0_l,
    input  logic [1:0]                   ctl_arr_sel,
    input  logic                         ctl_arr_load,
    input  logic                         ctl_arr_clr,
    input  logic [1:0]                   ctl_arxr_sel,
    input  logic                         ctl_arx_load,
    input  logic                         cram_br_load,
    input  logic                         cram_brx_load,
    input  logic [1:0]                   ctl_mq_sel,
    input  logic                         mq_in_left,
    input  logic                         mq_in_right,
    input  logic [WIDTH-1:0]             armm,
    input  logic [WIDTH-1:0]             cache_data,
    input  logic [WIDTH-1:0]             sh,
    input  logic [WIDTH-1:0]             vma_held_or_pc,
    output logic [WIDTH-1:0]             ar,
    output logic [WIDTH-1:0]             arx,
    output logic [WIDTH-1:0]             br,
    output logic [WIDTH-1:0]             brx,
    output logic [WIDTH-1:0]             mq,
    input  logic [$clog2(FM_BLOCKS)-1:0] fm_block,
    input  logic [$clog2(FM_ACS)-1:0]    fm_adr,
    input  logic                         con_fm_write_l,
    output logic                         fm_parity,
    output logic                         fm_parity_err,
    input  logic                         fm_parity_clr,
    input  logic                         ctl_ad_to_ebus,
    input  logic                         diag_read,
    input  logic [2:0]                   diag_sel,
    output logic [WIDTH-1:0]             ebus_d
);

    localparam int FM_DEPTH = FM_BLOCKS * FM_ACS;

    logic [WIDTH-1:0] ada;
    logic [WIDTH-1:0] adb;
    logic [WIDTH-1:0] adb_eff;
    logic [WIDTH-1:0] ad_bool;
    logic [WIDTH:0]   ad_sum;
    logic [WIDTH:0]   ad_gen;
    logic [WIDTH-1:0] fm_rdata;
    logic [WIDTH-1:0] diag_data;
    logic [FM_AW-1:0] fm_addr;

    assign fm_addr = FM_AW'({fm_block, fm_adr});

    always_comb begin
        ada = '0;
        if (!cram_ada_dis) begin
            case (ada_sel_e'(cram_ada_sel))
                ADA_AR:  ada = ar;
                ADA_ARX: ada = arx;
                ADA_MQ:  ada = mq;
                ADA_PC:  ada = vma_held_or_pc;
            endcase
        end
    end

    always_comb begin
        adb = '0;
        case (adb_sel_e'(cram_adb_sel))
            ADB_FM:  adb = fm_rdata;
            ADB_BRX: adb = brx;
            ADB_BR:  adb = br;
            ADB_AR:  adb = ar;
        endcase
    end

    // Every arithmetic function is folded into A + B' + cin by choosing the effective B operand.
    always_comb begin
        case (cram_ad_sel)
            AD_A:         adb_eff = '0;
            AD_A_PLUS_NB: adb_eff = ~adb;
            AD_A_PLUS_A:  adb_eff = ada;
            AD_A_MINUS_1: adb_eff = '1;
            default:      adb_eff = adb;
        endcase
    end

    assign ad_sum = {1'b0, ada} + {1'b0, adb_eff} + (WIDTH+1)'(ad_cry_in);
    // Carry out with zero carry-in is exactly the group generate term.
    assign ad_gen = {1'b0, ada} + {1'b0, adb_eff};

    // Boolean mode: the 4-bit select is the truth table indexed by {a, b}.
    always_comb begin
        ad_bool = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ad_bool[i] = cram_ad_sel[{ada[i], adb[i]}];
        end
    end

    always_comb begin
        if (cram_ad_boole) begin
            ad         = ad_bool;
            ad_cry_out = 1'b0;
            ad_cg      = 1'b0;
            ad_cp      = 1'b0;
        end else begin
            ad         = ad_sum[WIDTH-1:0];
            ad_cry_out = ad_sum[WIDTH];
            ad_cg      = ad_gen[WIDTH];
            ad_cp      = &(ada | adb_eff);
        end
    end

    assign ad_eq0_l = |ad;

    always_comb begin
        diag_data = '0;
        case (diag_sel_e'(diag_sel))
            DIAG_AR:   diag_data = ar;
            DIAG_BR:   diag_data = br;
            DIAG_MQ:   diag_data = mq;
            DIAG_FM:   diag_data = fm_rdata;
            DIAG_ARX:  diag_data = arx;
            DIAG_BRX:  diag_data = brx;
            DIAG_PC:   diag_data = vma_held_or_pc;
            DIAG_ZERO: diag_data = '0;
        endcase
    end

    always_ff @(posedge clk_edp_h or negedge rst_l) begin
        if (!rst_l) begin
            ar     <= '0;
            arx    <= '0;
            br     <= '0;
            brx    <= '0;
            mq     <= '0;
            ebus_d <= '0;
        end else begin
            if (ctl_arr_clr) begin
                ar <= '0;
            end else if (ctl_arr_load) begin
                case (arr_sel_e'(ctl_arr_sel))
                    ARR_ARMM:  ar <= armm;
                    ARR_CACHE: ar <= cache_data;
                    ARR_AD:    ar <= ad;
                    ARR_SH:    ar <= sh;
                endcase
            end

            if (ctl_arx_load) begin
                case (arxr_sel_e'(ctl_arxr_sel))
                    ARXR_CACHE: arx <= cache_data;
                    ARXR_AD:    arx <= ad;
                    ARXR_MQ:    arx <= mq;
                    ARXR_SH:    arx <= sh;
                endcase
            end

            // Non-blocking capture means BR/BRX always take the pre-edge AR/ARX.
            if (cram_br_load)  br  <= ar;
            if (cram_brx_load) brx <= arx;

            case (mq_sel_e'(ctl_mq_sel))
                MQ_HOLD: mq <= mq;
                MQ_SHR:  mq <= {mq_in_left, mq[WIDTH-1:1]};
                MQ_SHL:  mq <= {mq[WIDTH-2:0], mq_in_right};
                MQ_AD:   mq <= ad;
            endcase

            if (ctl_ad_to_ebus) begin
                ebus_d <= ad;
            end else if (diag_read) begin
                ebus_d <= diag_data;
            end else begin
                ebus_d <= '0;
            end
        end
    end

    edp_fm #(
        .WIDTH (WIDTH),
        .DEPTH (FM_DEPTH),
        .AW    (FM_AW)
    ) u_fm (
        .clk        (clk_edp_h),
        .rst_l      (rst_l),
        .adr        (fm_addr),
        .we         (!con_fm_write_l),
        .wdata      (ar),
        .parity_clr (fm_parity_clr),
        .rdata      (fm_rdata),
        .parity     (fm_parity),
        .parity_err (fm_parity_err)
    );

endmodule

// File: tb/tb_edp_slice_n.sv
// tb/tb_edp_slice_n.sv - self-checking bench for edp_slice_n with a behavioural reference model
module tb_edp_slice_n;

    localparam int W     = 6;
    localparam int FMB   = 8;
    localparam int FMA   = 16;
    localparam int DEPTH = FMB * FMA;

    logic clk_edp_h = 1'b0;
    logic rst_l     = 1'b0;
    always #5 clk_edp_h = ~clk_edp_h;

    logic [3:0]   cram_ad_sel;
    logic         cram_ad_boole, cram_ada_dis, ad_cry_in;
    logic [1:0]   cram_ada_sel, cram_adb_sel;
    logic         ad_cry_out, ad_cg, ad_cp, ad_eq0_l;
    logic [W-1:0] ad;
    logic [1:0]   ctl_arr_sel, ctl_arxr_sel, ctl_mq_sel;
    logic         ctl_arr_load, ctl_arr_clr, ctl_arx_load, cram_br_load, cram_brx_load;
    logic         mq_in_left, mq_in_right;
    logic [W-1:0] armm, cache_data, sh, vma_held_or_pc;
    logic [W-1:0] ar, arx, br, brx, mq, ebus_d;
    logic [2:0]   fm_block;
    logic [3:0]   fm_adr;
    logic         con_fm_write_l, fm_parity, fm_parity_err, fm_parity_clr;
    logic         ctl_ad_to_ebus, diag_read;
    logic [2:0]   diag_sel;

    edp_slice_n #(.WIDTH(W), .FM_BLOCKS(FMB), .FM_ACS(FMA)) dut (
        .clk_edp_h(clk_edp_h), .rst_l(rst_l),
        .cram_ad_sel(cram_ad_sel), .cram_ad_boole(cram_ad_boole),
        .cram_ada_sel(cram_ada_sel), .cram_ada_dis(cram_ada_dis),
        .cram_adb_sel(cram_adb_sel), .ad_cry_in(ad_cry_in),
        .ad_cry_out(ad_cry_out), .ad_cg(ad_cg), .ad_cp(ad_cp), .ad(ad), .ad_eq0_l(ad_eq0_l),
        .ctl_arr_sel(ctl_arr_sel), .ctl_arr_load(ctl_arr_load), .ctl_arr_clr(ctl_arr_clr),
        .ctl_arxr_sel(ctl_arxr_sel), .ctl_arx_load(ctl_arx_load),
        .cram_br_load(cram_br_load), .cram_brx_load(cram_brx_load),
        .ctl_mq_sel(ctl_mq_sel), .mq_in_left(mq_in_left), .mq_in_right(mq_in_right),
        .armm(armm), .cache_data(cache_data), .sh(sh), .vma_held_or_pc(vma_held_or_pc),
        .ar(ar), .arx(arx), .br(br), .brx(brx), .mq(mq),
        .fm_block(fm_block), .fm_adr(fm_adr), .con_fm_write_l(con_fm_write_l),
        .fm_parity(fm_parity), .fm_parity_err(fm_parity_err), .fm_parity_clr(fm_parity_clr),
        .ctl_ad_to_ebus(ctl_ad_to_ebus), .diag_read(diag_read), .diag_sel(diag_sel),
        .ebus_d(ebus_d)
    );

    int   n_chk  = 0;
    int   n_fail = 0;
    logic cmp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic odd6(input logic [W-1:0] v);
        return ($countones(v) % 2) == 0;
    endfunction

    // ---------------- reference model ----------------
    logic [W-1:0]     m_ar, m_arx, m_br, m_brx, m_mq, m_ebus;
    logic             m_err;
    logic [W-1:0]     m_fm_data [DEPTH];
    logic [DEPTH-1:0] m_par, m_written;

    int           m_idx, m_a, m_b, m_beff, m_sum;
    logic [W-1:0] m_fm, m_ad, m_diag, la, lb;
    logic         m_cout, m_cg, m_cp;

    always_comb begin
        m_idx  = int'({fm_block, fm_adr});
        m_fm   = m_fm_data[m_idx];
        m_a    = 0;
        m_b    = 0;
        m_beff = 0;
        m_sum  = 0;
        m_ad   = '0;
        m_cout = 1'b0;
        m_cg   = 1'b0;
        m_cp   = 1'b0;
        m_diag = '0;
        la     = '0;
        lb     = '0;
        if (!cram_ada_dis) begin
            case (cram_ada_sel)
                2'd0: m_a = int'(m_ar);
                2'd1: m_a = int'(m_arx);
                2'd2: m_a = int'(m_mq);
                default: m_a = int'(vma_held_or_pc);
            endcase
        end
        case (cram_adb_sel)
            2'd0: m_b = int'(m_fm);
            2'd1: m_b = int'(m_brx);
            2'd2: m_b = int'(m_br);
            default: m_b = int'(m_ar);
        endcase
        case (cram_ad_sel)
            4'd0: m_beff = 0;
            4'd2: m_beff = 63 - m_b;
            4'd3: m_beff = m_a;
            4'd4: m_beff = 63;
            default: m_beff = m_b;
        endcase
        la = W'(m_a);
        lb = W'(m_b);
        if (cram_ad_boole) begin
            // Sum of minterms selected by the function code.
            m_ad = ({W{cram_ad_sel[3]}} &  la &  lb) | ({W{cram_ad_sel[2]}} &  la & ~lb) |
                   ({W{cram_ad_sel[1]}} & ~la &  lb) | ({W{cram_ad_sel[0]}} & ~la & ~lb);
        end else begin
            m_sum  = m_a + m_beff + int'(ad_cry_in);
            m_ad   = W'(m_sum % 64);
            m_cout = (m_sum >= 64);
            m_cg   = ((m_a + m_beff) >= 64);
            m_cp   = ((m_a | m_beff) == 63);
        end
        case (diag_sel)
            3'd0: m_diag = m_ar;
            3'd1: m_diag = m_br;
            3'd2: m_diag = m_mq;
            3'd3: m_diag = m_fm;
            3'd4: m_diag = m_arx;
            3'd5: m_diag = m_brx;
            3'd6: m_diag = vma_held_or_pc;
            default: m_diag = '0;
        endcase
    end

    always @(posedge clk_edp_h or negedge rst_l) begin
        if (!rst_l) begin
            m_ar <= '0; m_arx <= '0; m_br <= '0; m_brx <= '0; m_mq <= '0;
            m_ebus <= '0; m_err <= 1'b0; m_written <= '0;
        end else begin
            if (ctl_arr_clr) m_ar <= '0;
            else if (ctl_arr_load) begin
                case (ctl_arr_sel)
                    2'd0: m_ar <= armm;
                    2'd1: m_ar <= cache_data;
                    2'd2: m_ar <= m_ad;
                    default: m_ar <= sh;
                endcase
            end
            if (ctl_arx_load) begin
                case (ctl_arxr_sel)
                    2'd0: m_arx <= cache_data;
                    2'd1: m_arx <= m_ad;
                    2'd2: m_arx <= m_mq;
                    default: m_arx <= sh;
                endcase
            end
            if (cram_br_load)  m_br  <= m_ar;
            if (cram_brx_load) m_brx <= m_arx;
            case (ctl_mq_sel)
                2'd1: m_mq <= W'(int'(m_mq) / 2 + (mq_in_left ? 32 : 0));
                2'd2: m_mq <= W'((int'(m_mq) * 2 + int'(mq_in_right)) % 64);
                2'd3: m_mq <= m_ad;
                default: m_mq <= m_mq;
            endcase
            if (!con_fm_write_l) begin
                m_fm_data[m_idx] <= m_ar;
                m_par[m_idx]     <= odd6(m_ar);
                m_written[m_idx] <= 1'b1;
            end
            if (fm_parity_clr) m_err <= 1'b0;
            else if (m_written[m_idx] && con_fm_write_l && (m_par[m_idx] != odd6(m_fm))) m_err <= 1'b1;
            m_ebus <= ctl_ad_to_ebus ? m_ad : (diag_read ? m_diag : '0);
        end
    end

    always @(negedge clk_edp_h) begin
        if (cmp_en && rst_l) begin
            check("ad", ad, m_ad);
            check("ad_cry_out", ad_cry_out, m_cout);
            check("ad_cg", ad_cg, m_cg);
            check("ad_cp", ad_cp, m_cp);
            check("ad_eq0_l", ad_eq0_l, m_ad != '0);
            check("ar", ar, m_ar);
            check("arx", arx, m_arx);
            check("br", br, m_br);
            check("brx", brx, m_brx);
            check("mq", mq, m_mq);
            check("ebus_d", ebus_d, m_ebus);
            check("fm_parity", fm_parity, odd6(m_fm));
            check("fm_parity_err", fm_parity_err, m_err);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk_edp_h);
        #1;
    endtask

    task automatic load_ar(input logic [W-1:0] v);
        ctl_arr_sel = 2'd0; armm = v; ctl_arr_load = 1'b1;
        step();
        ctl_arr_load = 1'b0;
    endtask

    task automatic set_br(input logic [W-1:0] v);
        load_ar(v);
        cram_br_load = 1'b1;
        step();
        cram_br_load = 1'b0;
    endtask

    task automatic rand_inputs();
        cram_ad_sel    = 4'($urandom);
        cram_ad_boole  = 1'($urandom);
        cram_ada_sel   = 2'($urandom);
        cram_ada_dis   = ($urandom_range(0, 7) == 0);
        cram_adb_sel   = 2'($urandom);
        ad_cry_in      = 1'($urandom);
        ctl_arr_sel    = 2'($urandom);
        ctl_arr_load   = 1'($urandom);
        ctl_arr_clr    = ($urandom_range(0, 7) == 0);
        ctl_arxr_sel   = 2'($urandom);
        ctl_arx_load   = 1'($urandom);
        cram_br_load   = 1'($urandom);
        cram_brx_load  = 1'($urandom);
        ctl_mq_sel     = 2'($urandom);
        mq_in_left     = 1'($urandom);
        mq_in_right    = 1'($urandom);
        armm           = W'($urandom);
        cache_data     = W'($urandom);
        sh             = W'($urandom);
        vma_held_or_pc = W'($urandom);
        fm_block       = 3'($urandom);
        fm_adr         = 4'($urandom);
        con_fm_write_l = ($urandom_range(0, 3) != 0);
        fm_parity_clr  = ($urandom_range(0, 7) == 0);
        ctl_ad_to_ebus = ($urandom_range(0, 3) == 0);
        diag_read      = 1'($urandom);
        diag_sel       = 3'($urandom);
    endtask

    initial begin
        cram_ad_sel = '0; cram_ad_boole = 0; cram_ada_sel = '0; cram_ada_dis = 0;
        cram_adb_sel = '0; ad_cry_in = 0; ctl_arr_sel = '0; ctl_arr_load = 0; ctl_arr_clr = 0;
        ctl_arxr_sel = '0; ctl_arx_load = 0; cram_br_load = 0; cram_brx_load = 0;
        ctl_mq_sel = '0; mq_in_left = 0; mq_in_right = 0; armm = '0; cache_data = '0;
        sh = '0; vma_held_or_pc = '0; fm_block = '0; fm_adr = '0; con_fm_write_l = 1;
        fm_parity_clr = 0; ctl_ad_to_ebus = 0; diag_read = 0; diag_sel = '0;

        #12;
        check("rst_ar", ar, 6'o00);
        check("rst_arx", arx, 6'o00);
        check("rst_br", br, 6'o00);
        check("rst_brx", brx, 6'o00);
        check("rst_mq", mq, 6'o00);
        check("rst_ebus", ebus_d, 6'o00);
        check("rst_err", fm_parity_err, 1'b0);
        @(posedge clk_edp_h);
        #1 rst_l = 1'b1;

        // Give every FM word defined contents.
        for (int i = 0; i < DEPTH; i++) begin
            load_ar(W'($urandom));
            {fm_block, fm_adr} = 7'(i);
            con_fm_write_l = 1'b0;
            step();
            con_fm_write_l = 1'b1;
        end
        cmp_en = 1'b1;

        // Arithmetic add with carry in, then wrap to zero.
        set_br(6'o05);
        load_ar(6'o12);
        cram_ad_sel = 4'd1; ad_cry_in = 1'b1; cram_ada_sel = 2'd0; cram_adb_sel = 2'd2;
        #1;
        check("add_ad", ad, 6'o20);
        check("add_cout", ad_cry_out, 1'b0);
        set_br(6'o01);
        load_ar(6'o77);
        ad_cry_in = 1'b0;
        #1;
        check("wrap_ad", ad, 6'o00);
        check("wrap_cout", ad_cry_out, 1'b1);
        check("wrap_eq0_l", ad_eq0_l, 1'b0);

        // Boolean AND.
        set_br(6'o17);
        load_ar(6'o52);
        cram_ad_boole = 1'b1; cram_ad_sel = 4'b1000;
        #1;
        check("and_ad", ad, 6'o12);
        check("and_cg", ad_cg, 1'b0);
        check("and_cp", ad_cp, 1'b0);
        cram_ad_boole = 1'b0;

        // FM write, move away, read back; then read-during-write.
        load_ar(6'o33);
        fm_block = 3'd2; fm_adr = 4'd5; con_fm_write_l = 1'b0;
        step();
        con_fm_write_l = 1'b1; fm_adr = 4'd6;
        step();
        fm_adr = 4'd5; cram_adb_sel = 2'd0; cram_ada_dis = 1'b1; cram_ad_sel = 4'd1;
        #1;
        check("fm_rd_ad", ad, 6'o33);
        check("fm_rd_par", fm_parity, 1'b1);
        load_ar(6'o07);
        con_fm_write_l = 1'b0;
        #1;
        check("fm_rdw_old", ad, 6'o33);
        step();
        con_fm_write_l = 1'b1;
        check("fm_rdw_new", ad, 6'o07);

        // Corrupted stored parity: clear wins over set, then the error is sticky until cleared.
        cmp_en = 1'b0;
        force dut.u_fm.stored_par = 1'b1;
        fm_parity_clr = 1'b1;
        step();
        check("perr_clr_prio", fm_parity_err, 1'b0);
        fm_parity_clr = 1'b0;
        step();
        check("perr_set", fm_parity_err, 1'b1);
        release dut.u_fm.stored_par;
        step();
        check("perr_sticky", fm_parity_err, 1'b1);
        fm_parity_clr = 1'b1;
        step();
        check("perr_clr", fm_parity_err, 1'b0);
        fm_parity_clr = 1'b0;
        step();
        check("perr_clean", fm_parity_err, 1'b0);
        cmp_en = 1'b1;
        cram_ada_dis = 1'b0;

        // ARX/BRX, clear priority, BR captures pre-edge AR.
        cache_data = 6'o25; ctl_arxr_sel = 2'd0; ctl_arx_load = 1'b1;
        step();
        ctl_arx_load = 1'b0; cram_brx_load = 1'b1;
        step();
        cram_brx_load = 1'b0;
        check("brx_load", brx, 6'o25);
        ctl_arr_clr = 1'b1; ctl_arr_load = 1'b1; armm = 6'o55;
        step();
        ctl_arr_clr = 1'b0; ctl_arr_load = 1'b0;
        check("ar_clr_prio", ar, 6'o00);
        load_ar(6'o21);
        armm = 6'o44; ctl_arr_load = 1'b1; cram_br_load = 1'b1;
        step();
        ctl_arr_load = 1'b0; cram_br_load = 1'b0;
        check("ar_new", ar, 6'o44);
        check("br_old_ar", br, 6'o21);

        // MQ load and shifts.
        cram_ad_sel = 4'd0; cram_ada_sel = 2'd0; ad_cry_in = 1'b0;
        load_ar(6'o40);
        ctl_mq_sel = 2'd3;
        step();
        check("mq_load", mq, 6'o40);
        ctl_mq_sel = 2'd1; mq_in_left = 1'b1;
        step();
        check("mq_shr", mq, 6'o60);
        ctl_mq_sel = 2'd2; mq_in_left = 1'b0; mq_in_right = 1'b1;
        step();
        check("mq_shl", mq, 6'o41);
        ctl_mq_sel = 2'd0; mq_in_right = 1'b0;

        // EBUS diag path, AD priority, asynchronous reset.
        load_ar(6'o44);
        diag_read = 1'b1; diag_sel = 3'd2;
        step();
        check("ebus_diag_mq", ebus_d, 6'o41);
        ctl_ad_to_ebus = 1'b1;
        step();
        check("ebus_ad_prio", ebus_d, 6'o44);
        #3 rst_l = 1'b0;
        #1;
        check("arst_ar", ar, 6'o00);
        check("arst_arx", arx, 6'o00);
        check("arst_br", br, 6'o00);
        check("arst_brx", brx, 6'o00);
        check("arst_mq", mq, 6'o00);
        check("arst_ebus", ebus_d, 6'o00);
        ctl_ad_to_ebus = 1'b0; diag_read = 1'b0;
        step();
        rst_l = 1'b1;

        // Randomised traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            rand_inputs();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/edp_slice_n.md
Name: edp_slice_n

Overview:
- Parametrised execution-data-path slice: next generation of the fixed 6-bit EDP bit-slice, generalised to WIDTH bits and configurable fast-memory (FM) depth.
- Holds AR, ARX, BR, BRX and MQ, the AD adder/boolean unit with group carry lookahead, and the FM array with per-word parity and a sticky parity-error flag.
- Provides a registered EBUS diagnostic/readout path. Slices are chained through carry and MQ shift links to build the full word.

Parameters:
WIDTH, 6, slice width in bits (multiple of 6, 6..36)
FM_BLOCKS, 8, number of AC blocks
FM_ACS, 16, ACs per block
FM_AW, $clog2(FM_BLOCKS*FM_ACS), derived FM address width

Ports:
clk_edp_h  in  1  slice clock, all state updates on rising edge
rst_l  in  1  asynchronous active-low reset
cram_ad_sel  in  4  AD function select
cram_ad_boole  in  1  1 = boolean mode, 0 = arithmetic
cram_ada_sel  in  2  ADA source: 0 AR, 1 ARX, 2 MQ, 3 vma_held_or_pc
cram_ada_dis  in  1  forces ADA = 0
cram_adb_sel  in  2  ADB source: 0 FM, 1 BRX, 2 BR, 3 AR
ad_cry_in  in  1  carry into slice LSB, from the less-significant neighbour
ad_cry_out  out  1  carry out of slice MSB
ad_cg, ad_cp  out  1  group generate / propagate
ad  out  WIDTH  AD result, combinational
ad_eq0_l  out  1  low when ad == 0
ctl_arr_sel  in  2  AR source: 0 armm, 1 cache_data, 2 AD, 3 sh
ctl_arr_load, ctl_arr_clr  in  1  AR load / clear
ctl_arxr_sel  in  2  ARX source: 0 cache_data, 1 AD, 2 MQ, 3 sh
ctl_arx_load  in  1  ARX load
cram_br_load, cram_brx_load  in  1  BR <= AR, BRX <= ARX
ctl_mq_sel  in  2  0 hold, 1 shift right, 2 shift left, 3 load AD
mq_in_left, mq_in_right  in  1  shift-in bits from neighbour slices
armm, cache_data, sh, vma_held_or_pc  in  WIDTH  data sources
ar, arx, br, brx, mq  out  WIDTH  register contents
fm_block  in  $clog2(FM_BLOCKS)  current AC block
fm_adr  in  $clog2(FM_ACS)  AC address
con_fm_write_l  in  1  low = write AR into FM at the edge
fm_parity  out  1  odd parity of the FM read word
fm_parity_err  out  1  sticky FM parity error
fm_parity_clr  in  1  clears fm_parity_err
ctl_ad_to_ebus  in  1  drive AD onto EBUS
diag_read  in  1  diagnostic read enable
diag_sel  in  3  diagnostic source select
ebus_d  out  WIDTH  registered EBUS data

Behaviour:
- Reset (asynchronous, rst_l low): AR, ARX, BR, BRX, MQ, ebus_d, fm_parity_err and all FM written bits clear to 0. FM data is not reset.
- Boolean mode: ad[i] = cram_ad_sel[{ada[i],adb[i]}], giving all 16 functions. ad_cry_out, ad_cg and ad_cp are 0.
- Arithmetic mode, with cin = ad_cry_in:
  - sel 0: A+cin
  - sel 1: A+B+cin
  - sel 2: A+~B+cin
  - sel 3: A+A+cin
  - sel 4: A-1+cin
  - sel 5..15: A+B+cin
  - ad_cp = &(a|b'); ad_cg is the standard group generate over the effective operands.
- AR: ctl_arr_clr has priority and sets AR to 0; otherwise ctl_arr_load loads the selected source. ARX loads likewise.
- BR/BRX capture pre-edge AR/ARX, so a same-cycle AR load plus BR load gives BR the old AR.
- MQ:
  - shift right: {mq_in_left, mq[W-1:1]}
  - shift left: {mq[W-2:0], mq_in_right}
  - bit 0 is MSB-end numbering is not used; index W-1 is most significant.
- FM read: asynchronous at {fm_block, fm_adr}.
- FM write: on the edge when con_fm_write_l = 0. The word gets AR plus its stored odd-parity bit, and the word's written bit is set.
- Read/write same address in the same cycle: read returns the old data; new data is visible the next cycle.
- fm_parity_err sets on the edge when the addressed word is written, not being written this cycle, and recomputed parity differs from the stored parity.
- Unwritten words never flag an error. fm_parity_clr has priority over set.
- EBUS, one-cycle latency: ebus_d <= ctl_ad_to_ebus ? ad : diag_read ? diag source : 0.
- Diag sources: 0 AR, 1 BR, 2 MQ, 3 FM, 4 ARX, 5 BRX, 6 PC, 7 zero.
- ctl_ad_to_ebus wins over diag_read.

Decomposition:
- Package edp_pkg: ada/adb/arr/arxr/mq/diag select enums, the AD function code constants, and an odd-parity function.
- One sub-module edp_fm (FM array, written bits, parity store/check); the rest of the logic stays in edp_slice_n.

Test Plan:
1. WIDTH=6: AR=6'o12, BR=6'o05, boole=0, sel=1, cin=1, ada=AR, adb=BR -> ad=6'o20, ad_cry_out=0. AR=6'o77, BR=1, cin=0 -> ad=0, ad_cry_out=1, ad_eq0_l=0.
2. Boole mode, sel=4'b1000 (AND): AR=6'o52, BR=6'o17 -> ad=6'o12, ad_cg=ad_cp=0.
3. AR=6'o33, FM write block 2 AC 5, then a different address, then read back -> ADB=6'o33 and fm_parity equals odd parity; corrupt the stored parity via a bench force -> fm_parity_err=1 next edge; fm_parity_clr -> 0.
4. ctl_arr_clr and ctl_arr_load asserted together -> AR=0. AR load 6'o44 with cram_br_load in the same cycle -> BR holds the old AR.
5. MQ=6'o40, shift right with mq_in_left=1 -> 6'o60; shift left with mq_in_right=1 -> 6'o41.
6. diag_read=1, diag_sel=2 with MQ=6'o41 -> ebus_d=6'o41 one cycle later. Assert ctl_ad_to_ebus simultaneously -> ebus_d=ad. Pull rst_l low mid-operation -> all registers and ebus_d are 0 immediately (asynchronous).
